// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp patterns and phase-length helpers for the
// two-road intersection sequencer.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR1   = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR2   = 3'd5,
      FLASH = 3'd6
   } phase_t;

   // Lamp patterns, bit order {R,Y,G}
   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_OFF = 3'b000;

   // Lengths are 9 bits wide so that a full 256-tick phase is representable
   typedef struct packed {
      logic [8:0] ns_g;
      logic [8:0] ew_g;
      logic [8:0] y;
      logic [8:0] ar;
   } timing_t;

   function automatic logic [8:0] phase_len(input phase_t p, input timing_t t);
      case (p)
         NS_G:       return t.ns_g;
         EW_G:       return t.ew_g;
         NS_Y, EW_Y: return t.y;
         AR1, AR2:   return t.ar;
         default:    return 9'd1;
      endcase
   endfunction

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         NS_G:    return NS_Y;
         NS_Y:    return AR1;
         AR1:     return EW_G;
         EW_G:    return EW_Y;
         EW_Y:    return AR2;
         default: return NS_G;
      endcase
   endfunction

   function automatic logic is_green(input phase_t p);
      return (p == NS_G) || (p == EW_G);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks
// (tick is high while the prescaler sits at DIV-1).
module tick_gen #(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_presc;
   logic         w_last;

   assign w_last = (r_presc == LAST);
   assign tick   = w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_last) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase sequencer with pedestrian green shortening.
// Optional night flashing mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int T_NS_G    = 30,
   parameter int T_EW_G    = 15,
   parameter int T_Y       = 3,
   parameter int T_AR      = 1,
   parameter int T_PED_MIN = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req,
   input  logic       night,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [7:0] count,
   output phase_t     phase,
   output logic       ped_ack,
   output logic       tick
);

   localparam timing_t TIMING = '{
      ns_g: 9'(T_NS_G),
      ew_g: 9'(T_EW_G),
      y:    9'(T_Y),
      ar:   9'(T_AR)
   };
   localparam logic [8:0] PED_MIN  = 9'(T_PED_MIN);
   localparam logic [7:0] PED_LOAD = 8'(T_PED_MIN - 1);

   logic       w_tick;
   phase_t     r_phase;
   phase_t     w_phase_next;
   logic [7:0] r_count;
   logic [7:0] w_count_next;
   logic       r_pending;
   logic       w_pending_next;
   logic       r_ped_ack;
   logic       w_serve;
`ifdef NIGHT_FLASH_EN
   logic       r_flash_on;
   logic       w_flash_next;
`else
   logic       w_unused_night;
   assign w_unused_night = night;
`endif

   // Count loaded when entering a phase: its length minus one
   function automatic logic [7:0] load_of(input phase_t p);
      logic [8:0] len_m1;
      len_m1 = phase_len(p, TIMING) - 9'd1;
      return len_m1[7:0];
   endfunction

   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase    <= NS_G;
         r_count    <= load_of(NS_G);
         r_pending  <= 1'b0;
         r_ped_ack  <= 1'b0;
`ifdef NIGHT_FLASH_EN
         r_flash_on <= 1'b0;
`endif
      end else begin
         r_phase    <= w_phase_next;
         r_count    <= w_count_next;
         r_pending  <= w_pending_next;
         r_ped_ack  <= w_serve;
`ifdef NIGHT_FLASH_EN
         r_flash_on <= w_flash_next;
`endif
      end
   end

   always_comb begin
      w_phase_next = r_phase;
      w_count_next = r_count;
      w_serve      = 1'b0;
`ifdef NIGHT_FLASH_EN
      w_flash_next = r_flash_on;
`endif
      if (w_tick) begin
`ifdef NIGHT_FLASH_EN
         if (night && (r_phase != FLASH)) begin
            w_phase_next = FLASH;
            w_count_next = 8'd0;
            w_flash_next = 1'b1;
         end else if (night) begin
            w_count_next = 8'd0;
            w_flash_next = ~r_flash_on;
         end else if (r_phase == FLASH) begin
            w_phase_next = AR2;
            w_count_next = load_of(AR2);
            w_flash_next = 1'b0;
         end else
`endif
         if (r_count == 8'd0) begin
            w_phase_next = next_phase(r_phase);
            w_count_next = load_of(next_phase(r_phase));
            w_serve      = is_green(r_phase) && r_pending;
         end else if (is_green(r_phase) && r_pending && ({1'b0, r_count} >= PED_MIN)) begin
            w_count_next = PED_LOAD;
         end else begin
            w_count_next = r_count - 8'd1;
         end
      end
   end

   // A new request on the serving cycle keeps the request pending
   assign w_pending_next = ped_req | (r_pending & ~w_serve);

   always_comb begin
      ns_light = L_RED;
      ew_light = L_RED;
      case (r_phase)
         NS_G: ns_light = L_GRN;
         NS_Y: ns_light = L_YEL;
         EW_G: ew_light = L_GRN;
         EW_Y: ew_light = L_YEL;
`ifdef NIGHT_FLASH_EN
         FLASH: begin
            ns_light = r_flash_on ? L_YEL : L_OFF;
            ew_light = r_flash_on ? L_YEL : L_OFF;
         end
`endif
         default: ;
      endcase
   end

   assign phase   = r_phase;
   assign count   = r_count;
   assign ped_ack = r_ped_ack;
   assign tick    = w_tick;

endmodule
